axi_rd_arbiter: RTL and testbench

Two-master, one-slave AXI-lite read-channel arbiter sharing the single memory read port between the instruction fetch unit (master 0) and the load/store unit (master 1). It accepts one read address from a winning master, forwards it to memory, routes the read data back to that master only, and then re-arbitrates. Only one transaction is outstanding at a time. Round-robin arbitration keeps the permanently-requesting fetch unit from starving loads.

---
 rtl/axi_rd_arbiter.sv | 167 ++++++++++++++++
 tb/tb_axi_rd_arbiter.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter
// Shares one AXI-lite read port between the instruction fetch unit (m0) and
// the load/store unit (m1). Exactly one read is in flight at a time: a master
// address is accepted in IDLE, replayed to memory from a local copy in ADDR,
// and the read data is steered back to the owning master in DATA. Ties are
// broken round-robin, so a fetch unit that never drops arvalid cannot starve
// loads.
module axi_rd_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  // master 0: instruction fetch unit
  input  logic              m0_arvalid,
  input  logic [ADDR_W-1:0] m0_araddr,
  output logic              m0_arready,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [1:0]        m0_rresp,
  input  logic              m0_rready,
  // master 1: load/store unit
  input  logic              m1_arvalid,
  input  logic [ADDR_W-1:0] m1_araddr,
  output logic              m1_arready,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [1:0]        m1_rresp,
  input  logic              m1_rready,
  // shared memory read port
  output logic              s_arvalid,
  output logic [ADDR_W-1:0] s_araddr,
  input  logic              s_arready,
  input  logic              s_rvalid,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic [1:0]        s_rresp,
  output logic              s_rready,
  // status
  output logic              grant,
  output logic              busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t            state;
  logic              grant_q;
  logic              last_q;
  logic              s_arvalid_q;
  logic              busy_q;
  logic [ADDR_W-1:0] addr_q;

  logic              req_any;
  logic              winner;
  logic              in_idle;
  logic              in_data;
  logic              owner_rready;

  // A lone requester always wins; when both request, the master that did
  // not win the previous arbitration goes first.
  function automatic logic pick_winner(input logic v0, input logic v1,
                                       input logic last);
    logic w;
    if (v0 && v1) begin
      w = ~last;
    end else begin
      w = v1;
    end
    return w;
  endfunction

  // Arbitration decode: which master would be accepted this cycle.
  always_comb begin
    req_any = m0_arvalid | m1_arvalid;
    winner  = pick_winner(m0_arvalid, m1_arvalid, last_q);
    in_idle = (state == ST_IDLE);
    in_data = (state == ST_DATA);
  end

  // Address-channel acceptance: only in IDLE, and only the winner.
  always_comb begin
    m0_arready = 1'b0;
    m1_arready = 1'b0;
    if (in_idle) begin
      m0_arready = m0_arvalid & ~winner;
      m1_arready = m1_arvalid &  winner;
    end
  end

  // Transaction FSM: capture the winning address, forward it, wait for data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      grant_q     <= 1'b0;
      last_q      <= 1'b0;
      addr_q      <= '0;
      s_arvalid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_any) begin
            state       <= ST_ADDR;
            grant_q     <= winner;
            last_q      <= winner;
            addr_q      <= winner ? m1_araddr : m0_araddr;
            s_arvalid_q <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        ST_ADDR: begin
          // addr_q is untouched here, so s_araddr holds through any stall
          if (s_arready) begin
            state       <= ST_DATA;
            s_arvalid_q <= 1'b0;
          end
        end
        ST_DATA: begin
          if (s_rvalid && s_rready) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
          end
        end
        default: begin
          state       <= ST_IDLE;
          s_arvalid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  // Read-data steering: memory data goes to the owner only; the other
  // master sees no valid and zero data. Outside DATA memory data is dropped.
  always_comb begin
    owner_rready = grant_q ? m1_rready : m0_rready;
    s_rready     = in_data & owner_rready;

    m0_rvalid = 1'b0;
    m0_rdata  = '0;
    m0_rresp  = 2'b00;
    m1_rvalid = 1'b0;
    m1_rdata  = '0;
    m1_rresp  = 2'b00;

    if (in_data) begin
      if (grant_q) begin
        m1_rvalid = s_rvalid;
        m1_rdata  = s_rdata;
        m1_rresp  = s_rresp;
      end else begin
        m0_rvalid = s_rvalid;
        m0_rdata  = s_rdata;
        m0_rresp  = s_rresp;
      end
    end
  end

  assign s_arvalid = s_arvalid_q;
  assign s_araddr  = addr_q;
  assign grant     = grant_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Self-checking bench for axi_rd_arbiter: directed scenarios followed by a
// randomized run. A memory model answers the shared port, two master models
// issue reads, a scoreboard holds the expected response per master, and a
// negedge monitor compares every output against a transaction-level model.
module tb_axi_rd_arbiter;
  localparam int AW = 32;
  localparam int DW = 64;

  typedef struct packed {
    logic [1:0]    resp;
    logic [DW-1:0] data;
  } rsp_t;

  logic          clk;
  logic          rst;
  logic          m0_arvalid, m0_arready, m0_rvalid, m0_rready;
  logic [AW-1:0] m0_araddr;
  logic [DW-1:0] m0_rdata;
  logic [1:0]    m0_rresp;
  logic          m1_arvalid, m1_arready, m1_rvalid, m1_rready;
  logic [AW-1:0] m1_araddr;
  logic [DW-1:0] m1_rdata;
  logic [1:0]    m1_rresp;
  logic          s_arvalid, s_arready, s_rvalid, s_rready;
  logic [AW-1:0] s_araddr;
  logic [DW-1:0] s_rdata;
  logic [1:0]    s_rresp;
  logic          grant, busy;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // master models
  logic [AW-1:0] req_q0[$];
  logic [AW-1:0] req_q1[$];
  rsp_t          exp_q0[$];
  rsp_t          exp_q1[$];
  bit            one_out0 = 1'b1;
  bit            one_out1 = 1'b1;
  int            hold0 = 0, hold1 = 0, hc0 = 0, hc1 = 0;
  int            req_cyc1 = 0;

  // memory model
  int            ar_delay = 0, r_delay = 0, ar_cnt = 0, r_cnt = 0;
  bit            r_pend = 1'b0;
  logic [AW-1:0] r_addr = '0;
  bit            rand_mode = 1'b0, junk_en = 1'b0, lat_chk = 1'b0;

  // observations
  int            served[$];
  int            ar_stall = 0, r_stall0 = 0, done0 = 0, done1 = 0, issued = 0;
  logic [DW-1:0] last_rdata0 = '0;

  // transaction-level reference: 0 = nothing outstanding,
  // 1 = address owed to memory, 2 = data owed to the owner
  int            mph = 0;
  bit            mlast = 1'b0, mgrant = 1'b0;
  logic [AW-1:0] maddr = '0;
  bit            any_req, win, own_rdy;
  rsp_t          e;

  axi_rd_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .m0_arvalid(m0_arvalid), .m0_araddr(m0_araddr), .m0_arready(m0_arready),
    .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rready(m0_rready),
    .m1_arvalid(m1_arvalid), .m1_araddr(m1_araddr), .m1_arready(m1_arready),
    .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rready(m1_rready),
    .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arready(s_arready),
    .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rready(s_rready),
    .grant(grant), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [DW-1:0] mem_data(input logic [AW-1:0] a);
    if (a == 32'h8000_0000) return 64'h0000_0013_0000_0297;
    return {a ^ 32'hDEAD_BEEF, ~a};
  endfunction

  function automatic logic [1:0] mem_resp(input logic [AW-1:0] a);
    return a[3:2] ^ a[5:4];
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: sample handshakes at negedge, update the models after the
  // edge, then drive the next input values.
  task automatic tick();
    bit            h0, h1, arh, rh, rs, sav, r0h, r1h, st0, st1, nv0, nv1;
    logic [AW-1:0] sa;
    @(negedge clk);
    rs  = rst;
    h0  = m0_arvalid && m0_arready;
    h1  = m1_arvalid && m1_arready;
    arh = s_arvalid && s_arready;
    rh  = r_pend && s_rvalid && s_rready;
    sav = s_arvalid;
    sa  = s_araddr;
    r0h = m0_rvalid && m0_rready;
    r1h = m1_rvalid && m1_rready;
    st0 = m0_rvalid && !m0_rready;
    st1 = m1_rvalid && !m1_rready;
    @(posedge clk);
    #1;
    if (rs) begin
      exp_q0.delete();
      exp_q1.delete();
      r_pend = 1'b0;
      ar_cnt = 0;
      r_cnt  = 0;
      hc0    = 0;
      hc1    = 0;
    end else begin
      if (h0 && req_q0.size() != 0) begin
        exp_q0.push_back({mem_resp(req_q0[0]), mem_data(req_q0[0])});
        void'(req_q0.pop_front());
      end
      if (h1 && req_q1.size() != 0) begin
        exp_q1.push_back({mem_resp(req_q1[0]), mem_data(req_q1[0])});
        void'(req_q1.pop_front());
      end
      if (rh) begin
        r_pend = 1'b0;
        if (rand_mode) r_delay = $urandom_range(0, 3);
      end else if (r_pend) begin
        r_cnt++;
      end
      if (arh) begin
        ar_cnt = 0;
        r_pend = 1'b1;
        r_cnt  = 0;
        r_addr = sa;
        if (rand_mode) ar_delay = $urandom_range(0, 3);
      end else if (sav) begin
        ar_cnt++;
      end
      if (r0h) begin
        hc0 = 0;
        if (rand_mode) hold0 = $urandom_range(0, 2);
      end else if (st0) begin
        hc0++;
      end
      if (r1h) begin
        hc1 = 0;
        if (rand_mode) hold1 = $urandom_range(0, 2);
      end else if (st1) begin
        hc1++;
      end
    end
    // memory outputs
    s_arready = (ar_cnt >= ar_delay);
    if (r_pend) begin
      s_rvalid = (r_cnt >= r_delay);
      s_rdata  = mem_data(r_addr);
      s_rresp  = mem_resp(r_addr);
    end else begin
      s_rvalid = junk_en ? 1'($urandom_range(0, 1)) : 1'b0;
      s_rdata  = {$urandom, $urandom};
      s_rresp  = 2'($urandom_range(0, 3));
    end
    // master outputs
    nv0 = (req_q0.size() != 0) && (!one_out0 || exp_q0.size() == 0);
    nv1 = (req_q1.size() != 0) && (!one_out1 || exp_q1.size() == 0);
    if (nv1 && !m1_arvalid) req_cyc1 = cyc;
    m0_arvalid = nv0;
    m0_araddr  = nv0 ? req_q0[0] : $urandom;
    m1_arvalid = nv1;
    m1_araddr  = nv1 ? req_q1[0] : $urandom;
    m0_rready  = (hc0 >= hold0);
    m1_rready  = (hc1 >= hold1);
  endtask

  task automatic wait_idle(input string name, input int max);
    int n;
    n = 0;
    while (!(req_q0.size() == 0 && req_q1.size() == 0 &&
             exp_q0.size() == 0 && exp_q1.size() == 0 && mph == 0)) begin
      if (n >= max) begin
        checks++;
        errors++;
        $display("FAIL %s: still busy after %0d cycles, required idle", name, max);
        return;
      end
      tick();
      n++;
    end
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Monitor: compare every cycle against the reference, then advance it.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        mph    = 0;
        mlast  = 1'b0;
        mgrant = 1'b0;
      end else begin
        any_req = m0_arvalid || m1_arvalid;
        win     = (m0_arvalid && m1_arvalid) ? !mlast : m1_arvalid;
        own_rdy = mgrant ? m1_rready : m0_rready;
        check1("busy", busy, mph != 0);
        check1("grant", grant, mgrant);
        check1("m0_arready", m0_arready, mph == 0 && m0_arvalid && !win);
        check1("m1_arready", m1_arready, mph == 0 && m1_arvalid && win);
        check1("s_arvalid", s_arvalid, mph == 1);
        if (mph == 1) check("s_araddr", DW'(s_araddr), DW'(maddr));
        check1("s_rready", s_rready, mph == 2 && own_rdy);
        check1("m0_rvalid", m0_rvalid, mph == 2 && !mgrant && s_rvalid);
        check1("m1_rvalid", m1_rvalid, mph == 2 && mgrant && s_rvalid);
        if (mph == 2) begin
          if (mgrant) check("m0_rdata_quiet", m0_rdata, '0);
          else        check("m1_rdata_quiet", m1_rdata, '0);
        end
        if (mph == 2 && s_rvalid && own_rdy) begin
          if ((mgrant ? exp_q1.size() : exp_q0.size()) == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_read: master %0d got data, expected none", mgrant);
          end else if (mgrant) begin
            e = exp_q1.pop_front();
            check("m1_rdata", m1_rdata, e.data);
            check("m1_rresp", DW'(m1_rresp), DW'(e.resp));
          end else begin
            e = exp_q0.pop_front();
            check("m0_rdata", m0_rdata, e.data);
            check("m0_rresp", DW'(m0_rresp), DW'(e.resp));
          end
        end
        if (m0_rvalid && m0_rready) begin
          served.push_back(0);
          done0++;
          last_rdata0 = m0_rdata;
        end
        if (m1_rvalid && m1_rready) begin
          served.push_back(1);
          done1++;
          if (lat_chk) check1("m1_latency_le6", (cyc - req_cyc1) <= 6, 1'b1);
        end
        if (s_arvalid && !s_arready) ar_stall++;
        if (m0_rvalid && !m0_rready) r_stall0++;
        case (mph)
          0: if (any_req) begin
               mgrant = win;
               mlast  = win;
               maddr  = win ? m1_araddr : m0_araddr;
               mph    = 1;
             end
          1: if (s_arready) mph = 2;
          default: if (s_rvalid && own_rdy) mph = 0;
        endcase
      end
    end
  end

  initial begin
    rst = 1'b1;
    m0_arvalid = 1'b0; m0_araddr = '0; m0_rready = 1'b1;
    m1_arvalid = 1'b0; m1_araddr = '0; m1_rready = 1'b1;
    s_arready = 1'b1; s_rvalid = 1'b0; s_rdata = '0; s_rresp = 2'b00;
    do_reset();

    // reset state
    check1("rst_busy", busy, 1'b0);
    check1("rst_grant", grant, 1'b0);
    check1("rst_s_arvalid", s_arvalid, 1'b0);
    check1("rst_s_rready", s_rready, 1'b0);
    check1("rst_m0_arready", m0_arready, 1'b0);
    check1("rst_m1_arready", m1_arready, 1'b0);
    check1("rst_m0_rvalid", m0_rvalid, 1'b0);
    check1("rst_m1_rvalid", m1_rvalid, 1'b0);

    // single IFU read
    req_q0.push_back(32'h8000_0000);
    wait_idle("t1_single", 30);
    check("t1_rdata", last_rdata0, 64'h0000_0013_0000_0297);
    check1("t1_grant", grant, 1'b0);
    check_int("t1_m1_reads", done1, 0);

    // simultaneous requests out of reset: LSU first
    do_reset();
    served.delete();
    req_q0.push_back(32'h8000_0004);
    req_q1.push_back(32'h8000_1000);
    wait_idle("t2_tie", 30);
    check_int("t2_count", served.size(), 2);
    check_int("t2_first", served.size() > 0 ? served[0] : -1, 1);
    check_int("t2_second", served.size() > 1 ? served[1] : -1, 0);

    // IFU requests continuously, LSU requests whenever it has nothing open
    do_reset();
    served.delete();
    one_out0 = 1'b0;
    one_out1 = 1'b1;
    for (int i = 0; i < 6; i++) req_q0.push_back(32'h0000_1000 + 32'(4 * i));
    for (int i = 0; i < 3; i++) req_q1.push_back(32'h0000_2000 + 32'(8 * i));
    lat_chk = 1'b1;
    wait_idle("t3_alternate", 100);
    lat_chk  = 1'b0;
    one_out0 = 1'b1;
    check_int("t3_count", served.size(), 9);
    for (int i = 0; i < 4; i++)
      check_int("t3_alternation", served.size() > i ? served[i] : -1, (i % 2 == 0) ? 1 : 0);

    // memory stalls the address phase for 5 cycles
    ar_delay = 5;
    ar_stall = 0;
    req_q1.push_back(32'h0000_3000);
    wait_idle("t4_ar_stall", 40);
    check_int("t4_stall_cycles", ar_stall, 5);
    ar_delay = 0;

    // owner holds rready low for 3 cycles of valid data
    hold0    = 3;
    r_stall0 = 0;
    req_q0.push_back(32'h0000_4010);
    wait_idle("t5_r_stall", 40);
    check_int("t5_stall_cycles", r_stall0, 3);
    hold0 = 0;

    // reset while waiting for data
    r_delay = 20;
    req_q0.push_back(32'h0000_5000);
    for (int i = 0; i < 20 && mph != 2; i++) tick();
    check_int("t6_reached_data", mph, 2);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check1("t6_busy", busy, 1'b0);
    check1("t6_s_rready", s_rready, 1'b0);
    check1("t6_grant", grant, 1'b0);
    r_delay = 0;
    done0   = 0;
    req_q0.push_back(32'h8000_0040);
    wait_idle("t6_after_reset", 30);
    check_int("t6_read_done", done0, 1);

    // randomized traffic
    do_reset();
    rand_mode = 1'b1;
    junk_en   = 1'b1;
    one_out0  = 1'($urandom_range(0, 1));
    one_out1  = 1'($urandom_range(0, 1));
    issued = 0;
    done0  = 0;
    done1  = 0;
    for (int i = 0; i < 1500; i++) begin
      if (req_q0.size() < 2 && $urandom_range(0, 2) == 0) begin
        req_q0.push_back($urandom);
        issued++;
      end
      if (req_q1.size() < 2 && $urandom_range(0, 3) == 0) begin
        req_q1.push_back($urandom);
        issued++;
      end
      tick();
    end
    wait_idle("random_drain", 400);
    check_int("random_all_done", done0 + done1, issued);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
